fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
Parametrised forwarding and hazard unit for the pipelined RISC-V core. It resolves operand forwarding for NUM_SRC source operands across NUM_STAGES in-flight pipeline stages, detects load-use hazards, and holds a small scoreboard of outstanding long-latency writes (mul/div, multi-cycle loads). From these it raises a single stall request to pipeline control.

Parameters:
REG_ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands checked per cycle
NUM_STAGES, 2, forwarding source stages; index 0 = youngest (EX/MEM), index NUM_STAGES-1 = oldest (MEM/WB)
SB_DEPTH, 4, scoreboard entries (outstanding long-latency ops)
LAT_W, 4, width of latency field and per-entry countdown

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stage_rd  in  NUM_STAGES x REG_ADDR_W  destination register per stage
stage_regwrite  in  NUM_STAGES  stage writes a register
stage_data_valid  in  NUM_STAGES  stage result is available for forwarding (0 for a load still in EX/MEM)
src_addr  in  NUM_SRC x REG_ADDR_W  source register addresses in ID/EX
src_used  in  NUM_SRC  source operand is actually read
fwd_sel  out  NUM_SRC x FS_W  0 = register file, k = stage k-1; FS_W = $clog2(NUM_STAGES+1)
issue_valid  in  1  long-latency op issues this cycle
issue_rd  in  REG_ADDR_W  its destination
issue_lat  in  LAT_W  cycles until its result is in the register file
issue_ready  out  1  scoreboard has a free entry
flush  in  1  discard all scoreboard entries
stall  out  1  hazard stall request
sb_busy  out  1  any scoreboard entry valid

Behaviour:
- Reset: synchronous on rst. All entries cleared on the next edge. While rst=1, all outputs are 0: fwd_sel=0, stall=0, issue_ready=0, sb_busy=0.
- Forwarding (combinational, zero latency), per src i:
  - A stage k matches if stage_regwrite[k] && stage_rd[k]!=0 && stage_rd[k]==src_addr[i].
  - fwd_sel[i] = k+1 for the lowest matching k; 0 if no stage matches or src_used[i]=0.
  - Stage rd or src_addr equal to x0 never forwards.
- Load-use: if the winning stage has stage_data_valid=0 and src_used[i]=1, the stall contribution is 1. fwd_sel still points to that stage. There is no fall-through to older stages.
- Scoreboard entry: {valid, rd, cnt[LAT_W]}.
  - Issue accepted when issue_valid && issue_ready.
  - If issue_rd!=0 && issue_lat!=0, the lowest-index free entry loads {1, issue_rd, issue_lat} at the next edge.
  - rd=0 or lat=0: accepted, no allocation.
- Countdown: each cycle every valid entry decrements cnt. An entry with cnt==1 becomes invalid at the edge. An entry therefore blocks for exactly issue_lat cycles after the issue edge.
- Duplicate rd: a second issue to a pending rd allocates a new entry. Stall lasts until all matching entries clear.
- issue_ready = !(all entries valid), computed from current state. An entry freeing this cycle does not make room for a same-cycle issue.
- Scoreboard stall: src_used[i] && any valid entry with rd==src_addr[i]. This applies regardless of any stage match (conservative WAW handling).
- stall = OR over all srcs of load-use and scoreboard contributions.
- sb_busy = OR of entry valid bits.
- flush: all entries invalid at the next edge. An issue in the same cycle is dropped. flush has priority over countdown.
- rst mid-countdown: same as flush. No stale entry survives.
- stall does not gate issue acceptance; pipeline control qualifies issue_valid.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds ports perf_clear (in, 1) and stall_cycles (out, 32).
  - stall_cycles increments each cycle stall=1 and saturates at 32'hFFFF_FFFF.
  - perf_clear or rst zeroes it at the next edge; clear wins over increment.
- Undefined: these ports and the counter do not exist. Forwarding and stall behaviour are identical in both builds.

Test Plan:
- Stage0 {rd=5, wr=1, dv=1}, stage1 {rd=5, wr=1}, src0=5 used -> fwd_sel[0]=1 (youngest wins), stall=0.
- Stage0 {rd=7, wr=1, dv=0}, src1=7 used -> fwd_sel[1]=1, stall=1. Same with src_used[1]=0 -> fwd_sel[1]=0, stall=0.
- Issue rd=9, lat=3; src0=9 used -> stall=1 for exactly 3 cycles after the issue edge, 0 on the 4th; sb_busy tracks the same window.
- Issue 4 ops lat=8 to rd=1..4 -> issue_ready=0. A 5th issue_valid is not allocated. After the first entry expires, issue_ready=1.
- Fill 2 entries, pulse flush with a simultaneous issue rd=3 -> next cycle sb_busy=0; src=3 gives no stall.
- HAZARD_PERF_EN build: force stall for 10 cycles -> stall_cycles=10. perf_clear -> 0. Preload near max -> counter holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding, load-use detection and long-latency write scoreboard merged into one stall.
// Define HAZARD_PERF_EN to add perf_clear / stall_cycles (saturating stall-cycle counter).

module fwd_src_lane #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_STAGES = 2,
    parameter int SB_DEPTH   = 4,
    parameter int FS_W       = 2
) (
    input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] i_stage_rd,
    input  logic [NUM_STAGES-1:0]                 i_stage_regwrite,
    input  logic [NUM_STAGES-1:0]                 i_stage_data_valid,
    input  logic [REG_ADDR_W-1:0]                 i_src_addr,
    input  logic                                  i_src_used,
    input  logic [SB_DEPTH-1:0]                   i_sb_vld,
    input  logic [SB_DEPTH-1:0][REG_ADDR_W-1:0]   i_sb_rd,
    output logic [FS_W-1:0]                       o_fwd_sel,
    output logic                                  o_stall
);
    logic [FS_W-1:0] w_sel;
    logic            w_dv;
    logic            w_sb_hit;

    // Scan oldest to youngest so the youngest match overwrites; no fall-through past it.
    always_comb begin
        w_sel = '0;
        w_dv  = 1'b1;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (i_stage_regwrite[k] && (i_stage_rd[k] != '0) && (i_stage_rd[k] == i_src_addr)) begin
                w_sel = FS_W'(k + 1);
                w_dv  = i_stage_data_valid[k];
            end
        end
    end

    always_comb begin
        w_sb_hit = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (i_sb_vld[e] && (i_sb_rd[e] == i_src_addr)) w_sb_hit = 1'b1;
        end
    end

    assign o_fwd_sel = i_src_used ? w_sel : '0;
    assign o_stall   = i_src_used && (((w_sel != '0) && !w_dv) || w_sb_hit);
endmodule

module fwd_hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int SB_DEPTH   = 4,
    parameter int LAT_W      = 4,
    localparam int FS_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] stage_rd,
    input  logic [NUM_STAGES-1:0]                 stage_regwrite,
    input  logic [NUM_STAGES-1:0]                 stage_data_valid,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]                    src_used,
    output logic [NUM_SRC-1:0][FS_W-1:0]          fwd_sel,
    input  logic                                  issue_valid,
    input  logic [REG_ADDR_W-1:0]                 issue_rd,
    input  logic [LAT_W-1:0]                      issue_lat,
    output logic                                  issue_ready,
    input  logic                                  flush,
    output logic                                  stall,
`ifdef HAZARD_PERF_EN
    input  logic                                  perf_clear,
    output logic [31:0]                           stall_cycles,
`endif
    output logic                                  sb_busy
);
    logic [SB_DEPTH-1:0]                 r_sb_vld;
    logic [SB_DEPTH-1:0][REG_ADDR_W-1:0] r_sb_rd;
    logic [SB_DEPTH-1:0][LAT_W-1:0]      r_sb_cnt;

    logic [NUM_SRC-1:0][FS_W-1:0] w_lane_sel;
    logic [NUM_SRC-1:0]           w_lane_stall;
    logic                         w_has_free;
    logic                         w_alloc;
    logic [SB_DEPTH-1:0]          w_alloc_oh;
    logic                         w_stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        fwd_src_lane #(
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_STAGES (NUM_STAGES),
            .SB_DEPTH   (SB_DEPTH),
            .FS_W       (FS_W)
        ) u_lane (
            .i_stage_rd         (stage_rd),
            .i_stage_regwrite   (stage_regwrite),
            .i_stage_data_valid (stage_data_valid),
            .i_src_addr         (src_addr[g]),
            .i_src_used         (src_used[g]),
            .i_sb_vld           (r_sb_vld),
            .i_sb_rd            (r_sb_rd),
            .o_fwd_sel          (w_lane_sel[g]),
            .o_stall            (w_lane_stall[g])
        );
    end

    // Free space is judged on current state only; an entry retiring this cycle is still full.
    assign w_has_free = !(&r_sb_vld);
    assign w_alloc_oh = ~r_sb_vld & (r_sb_vld + SB_DEPTH'(1));
    assign w_alloc    = issue_valid && w_has_free && (issue_rd != '0) && (issue_lat != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_vld <= '0;
            r_sb_rd  <= '0;
            r_sb_cnt <= '0;
        end else if (flush) begin
            r_sb_vld <= '0;
        end else begin
            for (int e = 0; e < SB_DEPTH; e++) begin
                if (w_alloc && w_alloc_oh[e]) begin
                    r_sb_vld[e] <= 1'b1;
                    r_sb_rd[e]  <= issue_rd;
                    r_sb_cnt[e] <= issue_lat;
                end else if (r_sb_vld[e]) begin
                    r_sb_cnt[e] <= r_sb_cnt[e] - LAT_W'(1);
                    if (r_sb_cnt[e] == LAT_W'(1)) r_sb_vld[e] <= 1'b0;
                end
            end
        end
    end

    assign w_stall     = |w_lane_stall;
    assign stall       = !rst && w_stall;
    assign fwd_sel     = rst ? '0 : w_lane_sel;
    assign issue_ready = !rst && w_has_free;
    assign sb_busy     = !rst && (|r_sb_vld);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst || perf_clear) r_stall_cycles <= '0;
        else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: forwarding vector table plus hand-written scoreboard/flush/reset sequences.
module tb_fwd_hazard_scoreboard;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][4:0] stage_rd;
    logic [1:0]      stage_regwrite, stage_data_valid;
    logic [1:0][4:0] src_addr;
    logic [1:0]      src_used;
    logic [1:0][1:0] fwd_sel;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [3:0]      issue_lat;
    logic            issue_ready, flush, stall, sb_busy;
`ifdef HAZARD_PERF_EN
    logic            perf_clear;
    logic [31:0]     stall_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    fwd_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .stage_rd(stage_rd), .stage_regwrite(stage_regwrite),
        .stage_data_valid(stage_data_valid), .src_addr(src_addr), .src_used(src_used),
        .fwd_sel(fwd_sel), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_lat(issue_lat), .issue_ready(issue_ready), .flush(flush), .stall(stall),
`ifdef HAZARD_PERF_EN
        .perf_clear(perf_clear), .stall_cycles(stall_cycles),
`endif
        .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0][4:0] srd;
        logic [1:0]      wr, dv;
        logic [1:0][4:0] sa;
        logic [1:0]      used;
        logic [1:0]      e0, e1;
        logic            es;
    } vec_t;

    vec_t tv[8];

    function automatic vec_t mk(input logic [4:0] r0, r1, input logic [1:0] wr, dv,
                                input logic [4:0] a0, a1, input logic [1:0] used,
                                input logic [1:0] e0, e1, input logic es);
        vec_t v;
        v.srd[0] = r0; v.srd[1] = r1; v.wr = wr; v.dv = dv;
        v.sa[0] = a0; v.sa[1] = a1; v.used = used;
        v.e0 = e0; v.e1 = e1; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
        issue_valid = 1'b1; issue_rd = rd; issue_lat = lat;
        tick();
        issue_valid = 1'b0;
        #1;
    endtask

    task automatic probe(input logic [4:0] a);
        src_addr[0] = a; src_used = 2'b01;
        #1;
    endtask

    initial begin
        tv[0] = mk(5, 5, 2'b11, 2'b11, 5, 0, 2'b11, 2'd1, 2'd0, 1'b0);   // youngest wins
        tv[1] = mk(7, 3, 2'b11, 2'b10, 3, 7, 2'b11, 2'd2, 2'd1, 1'b1);   // load-use on src1
        tv[2] = mk(7, 3, 2'b11, 2'b10, 3, 7, 2'b01, 2'd2, 2'd0, 1'b0);   // src1 unused
        tv[3] = mk(0, 0, 2'b11, 2'b00, 0, 4, 2'b11, 2'd0, 2'd0, 1'b0);   // x0 never forwards
        tv[4] = mk(6, 6, 2'b10, 2'b10, 6, 9, 2'b11, 2'd2, 2'd0, 1'b0);   // regwrite gates stage0
        tv[5] = mk(8, 8, 2'b11, 2'b01, 8, 8, 2'b11, 2'd1, 2'd1, 1'b0);   // older dv irrelevant
        tv[6] = mk(10, 10, 2'b11, 2'b10, 10, 0, 2'b01, 2'd1, 2'd0, 1'b1); // no fall-through
        tv[7] = mk(1, 12, 2'b10, 2'b00, 2, 12, 2'b11, 2'd0, 2'd2, 1'b1); // oldest-stage load-use

        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
`ifdef HAZARD_PERF_EN
        perf_clear = 1'b0;
`endif
        stage_rd = tv[1].srd; stage_regwrite = tv[1].wr; stage_data_valid = tv[1].dv;
        src_addr = tv[1].sa; src_used = tv[1].used;
        tick(); tick();
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd0);
        chk("rst_busy", 32'(sb_busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(issue_ready), 32'd1);
        chk("post_rst_busy", 32'(sb_busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            stage_rd = tv[i].srd; stage_regwrite = tv[i].wr; stage_data_valid = tv[i].dv;
            src_addr = tv[i].sa; src_used = tv[i].used;
            #1;
            chk($sformatf("vec%0d_sel0", i), 32'(fwd_sel[0]), 32'(tv[i].e0));
            chk($sformatf("vec%0d_sel1", i), 32'(fwd_sel[1]), 32'(tv[i].e1));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tv[i].es));
        end

        // Basic countdown: blocks for exactly lat cycles after the issue edge.
        stage_regwrite = 2'b00; src_addr = '0; src_used = 2'b00;
        probe(5'd9);
        issue(5'd9, 4'd3);
        chk("lat3_c1_stall", 32'(stall), 32'd1);
        chk("lat3_c1_busy", 32'(sb_busy), 32'd1);
        tick(); chk("lat3_c2_stall", 32'(stall), 32'd1);
        tick(); chk("lat3_c3_stall", 32'(stall), 32'd1);
        tick(); chk("lat3_c4_stall", 32'(stall), 32'd0);
        chk("lat3_c4_busy", 32'(sb_busy), 32'd0);

        // Fill all entries; overflow issue and same-cycle-retire issue are both dropped.
        for (int r = 1; r <= 4; r++) issue(5'(r), 4'd8);
        chk("full_ready", 32'(issue_ready), 32'd0);
        issue(5'd20, 4'd8);
        probe(5'd20); chk("overflow_dropped", 32'(stall), 32'd0);
        tick(); tick(); tick();
        chk("full_ready_e8", 32'(issue_ready), 32'd0);
        issue(5'd21, 4'd8);
        chk("ready_after_expire", 32'(issue_ready), 32'd1);
        probe(5'd21); chk("retire_no_room", 32'(stall), 32'd0);
        probe(5'd1);  chk("rd1_expired", 32'(stall), 32'd0);
        probe(5'd2);  chk("rd2_pending", 32'(stall), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0; #1;

        // Flush with simultaneous issue: everything dropped.
        issue(5'd11, 4'd8);
        issue(5'd12, 4'd8);
        flush = 1'b1;
        issue(5'd3, 4'd5);
        flush = 1'b0; #1;
        chk("flush_busy", 32'(sb_busy), 32'd0);
        chk("flush_ready", 32'(issue_ready), 32'd1);
        probe(5'd3);  chk("flush_issue_dropped", 32'(stall), 32'd0);
        probe(5'd11); chk("flush_rd11", 32'(stall), 32'd0);

        // Duplicate rd: stall persists until the longer entry clears.
        probe(5'd13);
        issue(5'd13, 4'd2);
        issue(5'd13, 4'd4);
        tick(); chk("dup_e3_stall", 32'(stall), 32'd1);
        tick(); tick(); chk("dup_e5_stall", 32'(stall), 32'd1);
        tick(); chk("dup_e6_stall", 32'(stall), 32'd0);
        chk("dup_e6_busy", 32'(sb_busy), 32'd0);
        issue(5'd0, 4'd5);  chk("rd0_no_alloc", 32'(sb_busy), 32'd0);
        issue(5'd14, 4'd0); chk("lat0_no_alloc", 32'(sb_busy), 32'd0);

        // Scoreboard stall applies even when a ready stage forwards the same register.
        issue(5'd15, 4'd3);
        stage_rd[0] = 5'd15; stage_regwrite = 2'b01; stage_data_valid = 2'b01;
        probe(5'd15);
        chk("waw_sel", 32'(fwd_sel[0]), 32'd1);
        chk("waw_stall", 32'(stall), 32'd1);
        stage_regwrite = 2'b00;
        flush = 1'b1; tick(); flush = 1'b0; #1;

        // Reset mid-countdown clears the scoreboard.
        probe(5'd16);
        issue(5'd16, 4'd6);
        rst = 1'b1; #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_ready", 32'(issue_ready), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("rst_mid_busy", 32'(sb_busy), 32'd0);
        chk("rst_mid_after_stall", 32'(stall), 32'd0);

`ifdef HAZARD_PERF_EN
        stage_rd[0] = 5'd7; stage_regwrite = 2'b01; stage_data_valid = 2'b00;
        perf_clear = 1'b1;
        probe(5'd7);
        tick();
        perf_clear = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        stage_regwrite = 2'b00; #1;
        tick();
        chk("perf_count10", stall_cycles, 32'd10);
        perf_clear = 1'b1; tick(); perf_clear = 1'b0; #1;
        chk("perf_clear", stall_cycles, 32'd0);
        dut.r_stall_cycles = 32'hFFFF_FFFD;
        stage_regwrite = 2'b01; #1;
        for (int c = 0; c < 4; c++) tick();
        chk("perf_saturate", stall_cycles, 32'hFFFF_FFFF);
        stage_regwrite = 2'b00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
